// File: rtl/mem_dual_access_unit.sv
// Dual-port memory initiator: fetch on read port A, loads on read port B, byte-masked stores.
// Optional build macro: MEM_ACCESS_MISALIGN_TRAP_EN (suppress and flag misaligned accesses).
module mem_dual_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  lsu_valid,
  input  logic                  lsu_wr,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  req_ready,
  output logic                  rsp_fetch_valid,
  output logic [INST_WIDTH-1:0] rsp_inst,
  output logic                  rsp_lsu_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  pMem_bRdEn,
  output logic [ADDR_WIDTH-1:0] pMem_bRdAddrA,
  output logic [ADDR_WIDTH-1:0] pMem_bRdAddrB,
  output logic                  pMem_bWrEn,
  output logic [ADDR_WIDTH-1:0] pMem_bWrAddr,
  output logic [DATA_WIDTH-1:0] pMem_bWrData,
  output logic                  pMem_bWrMask_0,
  output logic                  pMem_bWrMask_1,
  output logic                  pMem_bWrMask_2,
  output logic                  pMem_bWrMask_3,
  input  logic [INST_WIDTH-1:0] pMem_bRdDataA,
  input  logic [DATA_WIDTH-1:0] pMem_bRdDataB
);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  // Size 3 is reserved and behaves exactly like a word everywhere below.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic raw;
    case (size)
      SZ_BYTE: raw = 1'b0;
      SZ_HALF: raw = a[0];
      default: raw = (a != 2'b00);
    endcase
    return TRAP_EN && raw;
  endfunction

  // Without trapping, the low address bits that would misalign are simply dropped.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] off;
    if (TRAP_EN) begin
      off = a;
    end else begin
      case (size)
        SZ_BYTE: off = a;
        SZ_HALF: off = {a[1], 1'b0};
        default: off = 2'b00;
      endcase
    end
    return off;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  state_t state, state_nxt;

  logic                  f_vld, f_mis;
  logic                  l_vld, l_wr, l_uns, l_mis;
  logic [1:0]            l_size, l_off;
  logic [3:0]            mask_q;

  logic                  accept;
  logic                  in_fmis, in_lmis;
  logic [1:0]            in_off;
  logic [DATA_WIDTH-1:0] ld_shift, ld_ext;

  assign accept  = (state == IDLE) && (fetch_valid || lsu_valid);
  assign in_fmis = TRAP_EN && (fetch_addr[1:0] != 2'b00);
  assign in_lmis = lsu_misaligned(lsu_size, lsu_addr[1:0]);
  assign in_off  = lane_offset(lsu_size, lsu_addr[1:0]);

  // NOTE: all state is updated with non-blocking assignments and a synchronous reset,
  // so every register samples the same pre-edge values regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request capture: both channels are latched together with their valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_vld  <= 1'b0;
      f_mis  <= 1'b0;
      l_vld  <= 1'b0;
      l_wr   <= 1'b0;
      l_uns  <= 1'b0;
      l_mis  <= 1'b0;
      l_size <= 2'b00;
      l_off  <= 2'b00;
    end else if (accept) begin
      f_vld  <= fetch_valid;
      f_mis  <= in_fmis;
      l_vld  <= lsu_valid;
      l_wr   <= lsu_wr;
      l_uns  <= lsu_unsigned;
      l_mis  <= in_lmis;
      l_size <= lsu_size;
      l_off  <= in_off;
    end
  end

  // Bus address/data registers only move for a channel that will really access
  // memory, so the model never sees address churn from idle or trapped requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      pMem_bRdAddrA <= '0;
      pMem_bRdAddrB <= '0;
      pMem_bWrAddr  <= '0;
      pMem_bWrData  <= '0;
      mask_q        <= 4'b0000;
    end else if (accept) begin
      if (fetch_valid && !in_fmis)
        pMem_bRdAddrA <= {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
      if (lsu_valid && !in_lmis) begin
        if (lsu_wr) begin
          pMem_bWrAddr <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
          pMem_bWrData <= lsu_wdata << {in_off, 3'b000};
          mask_q       <= lane_mask(lsu_size, in_off);
        end else begin
          pMem_bRdAddrB <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
        end
      end
    end
  end

  assign ld_shift = pMem_bRdDataB >> {l_off, 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (l_size)
      SZ_BYTE: ld_ext = {{(DATA_WIDTH-8){!l_uns && ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_ext = {{(DATA_WIDTH-16){!l_uns && ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Read data is combinational from the model, so it is captured at the end of ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_inst  <= '0;
      rsp_rdata <= '0;
    end else if (state == ACCESS) begin
      if (f_vld) rsp_inst  <= f_mis ? '0 : pMem_bRdDataA;
      if (l_vld) rsp_rdata <= (l_wr || l_mis) ? '0 : ld_ext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    pMem_bRdEn      = 1'b0;
    pMem_bWrEn      = 1'b0;
    rsp_fetch_valid = 1'b0;
    rsp_lsu_valid   = 1'b0;
    rsp_err         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (fetch_valid || lsu_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        pMem_bRdEn = (f_vld && !f_mis) || (l_vld && !l_wr && !l_mis);
        pMem_bWrEn = l_vld && l_wr && !l_mis;
        state_nxt  = RESP;
      end
      RESP: begin
        rsp_fetch_valid = f_vld;
        rsp_lsu_valid   = l_vld;
        rsp_err         = (f_vld && f_mis) || (l_vld && l_mis);
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pMem_bWrMask_0 = pMem_bWrEn & mask_q[0];
  assign pMem_bWrMask_1 = pMem_bWrEn & mask_q[1];
  assign pMem_bWrMask_2 = pMem_bWrEn & mask_q[2];
  assign pMem_bWrMask_3 = pMem_bWrEn & mask_q[3];

endmodule

// File: tb/tb_mem_dual_access_unit.sv
// Self-checking bench for mem_dual_access_unit: vector table plus scoreboard, with a
// small byte-masked memory model behind the pMem bus.
module tb_mem_dual_access_unit;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock, reset;
  logic        fetch_valid, lsu_valid, lsu_wr, lsu_unsigned;
  logic [31:0] fetch_addr, lsu_addr, lsu_wdata;
  logic [1:0]  lsu_size;
  logic        req_ready, rsp_fetch_valid, rsp_lsu_valid, rsp_err;
  logic [31:0] rsp_inst, rsp_rdata;
  logic        pMem_bRdEn, pMem_bWrEn;
  logic [31:0] pMem_bRdAddrA, pMem_bRdAddrB, pMem_bWrAddr, pMem_bWrData;
  logic        pMem_bWrMask_0, pMem_bWrMask_1, pMem_bWrMask_2, pMem_bWrMask_3;
  logic [31:0] pMem_bRdDataA, pMem_bRdDataB;
  logic [3:0]  wr_mask;

  mem_dual_access_unit dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .lsu_valid(lsu_valid), .lsu_wr(lsu_wr), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .req_ready(req_ready),
    .rsp_fetch_valid(rsp_fetch_valid), .rsp_inst(rsp_inst),
    .rsp_lsu_valid(rsp_lsu_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pMem_bRdEn(pMem_bRdEn), .pMem_bRdAddrA(pMem_bRdAddrA), .pMem_bRdAddrB(pMem_bRdAddrB),
    .pMem_bWrEn(pMem_bWrEn), .pMem_bWrAddr(pMem_bWrAddr), .pMem_bWrData(pMem_bWrData),
    .pMem_bWrMask_0(pMem_bWrMask_0), .pMem_bWrMask_1(pMem_bWrMask_1),
    .pMem_bWrMask_2(pMem_bWrMask_2), .pMem_bWrMask_3(pMem_bWrMask_3),
    .pMem_bRdDataA(pMem_bRdDataA), .pMem_bRdDataB(pMem_bRdDataB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: 256 words, preloaded whenever reset is sampled.
  logic [31:0] mem [0:255];
  assign wr_mask       = {pMem_bWrMask_3, pMem_bWrMask_2, pMem_bWrMask_1, pMem_bWrMask_0};
  assign pMem_bRdDataA = mem[pMem_bRdAddrA[9:2]];
  assign pMem_bRdDataB = mem[pMem_bRdAddrB[9:2]];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h1234_5678;
      mem[1]   <= 32'h0000_0013;
      mem[64]  <= 32'h8001_7FFF;
      mem[128] <= 32'hDEAD_BEEF;
    end else if (pMem_bWrEn) begin
      for (int k = 0; k < 4; k++)
        if (wr_mask[k]) mem[pMem_bWrAddr[9:2]][8*k +: 8] <= pMem_bWrData[8*k +: 8];
    end
  end

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        lv;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] la;
    logic [31:0] wd;
    logic [31:0] e_inst;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        fv;
    logic        lv;
    logic [31:0] inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic lv,
                              input logic wr, input logic [1:0] sz, input logic un,
                              input logic [31:0] la, input logic [31:0] wd,
                              input logic [31:0] ei, input logic [31:0] er, input logic ee);
    vec_t v;
    v.fv = fv; v.fa = fa; v.lv = lv; v.wr = wr; v.sz = sz; v.un = un;
    v.la = la; v.wd = wd; v.e_inst = ei; v.e_rdata = er; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drives one request, optionally records its expected response, and returns
  // at the falling edge inside the ACCESS cycle.
  task automatic send(input vec_t v, input bit push);
    int   n;
    exp_t e;
    @(negedge clock);
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_req", req_ready, 1);
    fetch_valid  = v.fv;
    fetch_addr   = v.fa;
    lsu_valid    = v.lv;
    lsu_wr       = v.wr;
    lsu_size     = v.sz;
    lsu_unsigned = v.un;
    lsu_addr     = v.la;
    lsu_wdata    = v.wd;
    if (push) begin
      e.fv = v.fv; e.lv = v.lv; e.inst = v.e_inst; e.rdata = v.e_rdata; e.err = v.e_err;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    fetch_valid = 1'b0;
    lsu_valid   = 1'b0;
    @(negedge clock);
  endtask

  // Waits (bounded) for the response pulse and compares it with the scoreboard head.
  task automatic wait_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(rsp_fetch_valid || rsp_lsu_valid) && n < 6);
    check({tag, "_latency"}, n, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_fvalid"}, rsp_fetch_valid, e.fv);
      check({tag, "_lvalid"}, rsp_lsu_valid, e.lv);
      if (e.fv) check({tag, "_inst"}, rsp_inst, e.inst);
      if (e.lv) check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, rsp_err, e.err);
    end
  endtask

  initial begin
    vec_t v;
    bit   seen;

    reset = 1'b1;
    fetch_valid = 1'b0; fetch_addr = '0; lsu_valid = 1'b0; lsu_wr = 1'b0;
    lsu_size = 2'd0; lsu_unsigned = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_ready", req_ready, 1);
    check("rst_rden", pMem_bRdEn, 0);
    check("rst_wren", pMem_bWrEn, 0);
    check("rst_mask", wr_mask, 0);
    check("rst_rsp_valids", {rsp_fetch_valid, rsp_lsu_valid, rsp_err}, 0);
    check("rst_rsp_data", rsp_inst | rsp_rdata, 0);
    check("rst_addr", pMem_bRdAddrA | pMem_bRdAddrB | pMem_bWrAddr | pMem_bWrData, 0);

    // Vector table: loads/stores/extension cases, expected values derived by hand
    vecs[0]  = mk(0, 0, 1, 0, 2'd1, 0, 32'h8000_0102, 0, 0, 32'hFFFF_8001, 0);
    vecs[1]  = mk(0, 0, 1, 0, 2'd1, 1, 32'h8000_0102, 0, 0, 32'h0000_8001, 0);
    vecs[2]  = mk(0, 0, 1, 0, 2'd0, 0, 32'h8000_0101, 0, 0, 32'h0000_007F, 0);
    vecs[3]  = mk(0, 0, 1, 0, 2'd0, 0, 32'h8000_0103, 0, 0, 32'hFFFF_FF80, 0);
    vecs[4]  = mk(0, 0, 1, 0, 2'd0, 1, 32'h8000_0103, 0, 0, 32'h0000_0080, 0);
    vecs[5]  = mk(0, 0, 1, 0, 2'd1, 0, 32'h8000_0100, 0, 0, 32'h0000_7FFF, 0);
    vecs[6]  = mk(0, 0, 1, 0, 2'd2, 0, 32'h8000_0200, 0, 0, 32'hDEAD_BEEF, 0);
    vecs[7]  = mk(0, 0, 1, 1, 2'd2, 0, 32'h8000_0204, 32'hCAFE_F00D, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 2'd2, 0, 32'h8000_0204, 0, 0, 32'hCAFE_F00D, 0);
    vecs[9]  = mk(0, 0, 1, 1, 2'd1, 0, 32'h8000_0206, 32'h0000_1234, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 2'd2, 0, 32'h8000_0204, 0, 0, 32'h1234_F00D, 0);
    vecs[11] = mk(0, 0, 1, 0, 2'd3, 0, 32'h8000_0200, 0, 0, 32'hDEAD_BEEF, 0);
    vecs[12] = mk(0, 0, 1, 0, 2'd1, 0, 32'h8000_0101, 0, 0,
                  TRAP ? 32'h0 : 32'h0000_7FFF, TRAP);
    vecs[13] = mk(0, 0, 1, 1, 2'd2, 0, 32'h8000_0206, 32'h5555_AAAA, 0, 0, TRAP);
    vecs[14] = mk(0, 0, 1, 0, 2'd2, 0, 32'h8000_0204, 0, 0,
                  TRAP ? 32'h1234_F00D : 32'h5555_AAAA, 0);
    vecs[15] = mk(1, 32'h8000_0004, 1, 0, 2'd0, 1, 32'h8000_0202, 0,
                  32'h0000_0013, 32'h0000_00AD, 0);

    for (int i = 0; i < 16; i++) begin
      send(vecs[i], 1'b1);
      check($sformatf("v%0d_early_rsp", i), {rsp_fetch_valid, rsp_lsu_valid}, 0);
      wait_rsp($sformatf("v%0d", i));
    end

    // Misaligned fetch, then aligned fetch
    v = mk(1, 32'h8000_0006, 0, 0, 0, 0, 0, 0, TRAP ? 32'h0 : 32'h0000_0013, 0, TRAP);
    send(v, 1'b1);
    check("fmis_rden", pMem_bRdEn, TRAP ? 0 : 1);
    wait_rsp("fmis");
    v = mk(1, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 32'h0000_0013, 0, 0);
    send(v, 1'b1);
    check("fetch_rden", pMem_bRdEn, 1);
    check("fetch_addr_a", pMem_bRdAddrA, 32'h8000_0004);
    check("fetch_wren", pMem_bWrEn, 0);
    wait_rsp("fetch");

    // Byte store into the top lane, then read the word back
    v = mk(0, 0, 1, 1, 2'd0, 0, 32'h8000_0103, 32'h0000_00AB, 0, 0, 0);
    send(v, 1'b1);
    check("stb_wren", pMem_bWrEn, 1);
    check("stb_rden", pMem_bRdEn, 0);
    check("stb_wraddr", pMem_bWrAddr, 32'h8000_0100);
    check("stb_wrdata", pMem_bWrData, 32'hAB00_0000);
    check("stb_mask", wr_mask, 4'b1000);
    wait_rsp("stb");
    check("stb_wren_after", pMem_bWrEn, 0);
    check("stb_mask_after", wr_mask, 0);
    check("stb_wraddr_hold", pMem_bWrAddr, 32'h8000_0100);
    v = mk(0, 0, 1, 0, 2'd2, 0, 32'h8000_0100, 0, 0, 32'hAB01_7FFF, 0);
    send(v, 1'b1);
    wait_rsp("stb_readback");

    // Simultaneous fetch and word load
    v = mk(1, 32'h8000_0000, 1, 0, 2'd2, 0, 32'h8000_0200, 0,
           32'h1234_5678, 32'hDEAD_BEEF, 0);
    send(v, 1'b1);
    check("dual_ready_access", req_ready, 0);
    check("dual_rden", pMem_bRdEn, 1);
    check("dual_addr_a", pMem_bRdAddrA, 32'h8000_0000);
    check("dual_addr_b", pMem_bRdAddrB, 32'h8000_0200);
    wait_rsp("dual");
    check("dual_ready_resp", req_ready, 0);
    @(negedge clock);
    check("dual_pulse_end", {rsp_fetch_valid, rsp_lsu_valid}, 0);
    check("dual_ready_back", req_ready, 1);

    // Reset during the ACCESS cycle of a store: no response may follow
    v = mk(0, 0, 1, 1, 2'd2, 0, 32'h8000_0300, 32'h0BAD_F00D, 0, 0, 0);
    send(v, 1'b0);
    check("abort_wren", pMem_bWrEn, 1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("abort_ready", req_ready, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (rsp_fetch_valid || rsp_lsu_valid) seen = 1'b1;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_idle_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
